// File: rtl/izh_spike_pkg.sv
// Shared types and constants for the Izhikevich spike decoder.
// Voltages are signed 2.6 fixed point: ONE = 1.0, THRESH_DEF = 0.25.
package izh_spike_pkg;

    localparam int              ISI_W_DEF      = 12;
    localparam int              EVT_W          = ISI_W_DEF + 2;
    localparam logic signed [7:0] ONE          = 8'sd64;
    localparam logic signed [7:0] THRESH_DEF   = 8'sd16;
    localparam logic [7:0]      HYST_DEF       = 8'd8;
    localparam logic [11:0]     BURST_ISI_DEF  = 12'd8;
    localparam int              FIFO_DEPTH_DEF = 4;
    localparam logic [15:0]     WINDOW_DEF     = 16'd1024;

    // One queued event per spike, MSB first: {first, burst, isi}
    typedef struct packed {
        logic                 first;
        logic                 burst;
        logic [ISI_W_DEF-1:0] isi;
    } evt_t;

    // Detector state: armed below threshold, or waiting for re-arm
    typedef enum logic {
        BELOW = 1'b0,
        ABOVE = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/izh_evt_fifo.sv
// Synchronous event FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable. A push is taken when not full or when a pop
// frees a slot in the same cycle. head reads 0 while empty.
module izh_evt_fifo
#(
    parameter int W     = 14,
    parameter int DEPTH = 4
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = empty ? {W{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer advance; reset empties the queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/izh_spike_decoder.sv
// Spike decoder for the neuron's 2.6 membrane-voltage stream: threshold
// with hysteresis, saturating ISI measurement, burst flag, event FIFO.
// Optional spike-rate window enabled by defining SPIKE_RATE_EN.
module izh_spike_decoder
    import izh_spike_pkg::*;
#(
    parameter logic signed [7:0] THRESH     = THRESH_DEF,
    parameter logic [7:0]        HYST       = HYST_DEF,
    parameter int                ISI_W      = ISI_W_DEF,
    parameter logic [ISI_W-1:0]  BURST_ISI  = BURST_ISI_DEF,
    parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [15:0]       WINDOW     = WINDOW_DEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic signed [7:0]       v_sample,
    output logic                    spike_out,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [ISI_W+1:0]        evt_data,
    output logic                    overflow,
    output logic [15:0]             rate_count,
    output logic                    rate_valid
);

    localparam int EW = ISI_W + 2;
    localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};
    // Re-arm level in 9 bits so THRESH - HYST cannot wrap
    localparam logic signed [8:0] THRESH9 = {THRESH[7], THRESH};
    localparam logic signed [8:0] HYST9   = {1'b0, HYST};
    localparam logic signed [8:0] REARM9  = THRESH9 - HYST9;

    fsm_state_t        state_r;
    fsm_state_t        state_s;
    logic              spike_s;
    logic signed [8:0] v9_s;
    logic [ISI_W-1:0]  isi_cnt_r;
    logic [ISI_W-1:0]  isi_inc_s;
    logic              first_pending_r;
    logic              burst_s;
    logic [EW-1:0]     evt_s;
    logic              spike_out_r;
    logic              overflow_r;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;

    assign v9_s      = {v_sample[7], v_sample};
    assign isi_inc_s = (isi_cnt_r == ISI_MAX) ? ISI_MAX : (isi_cnt_r + ISI_ONE);
    assign burst_s   = !first_pending_r && (isi_inc_s <= BURST_ISI);
    assign evt_s     = {first_pending_r, burst_s, isi_inc_s};
    assign pop_s     = !fifo_empty_s && evt_ready;

    // Detector state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= BELOW;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and spike detection; only valid samples advance the FSM
    always_comb begin
        state_s = state_r;
        spike_s = 1'b0;
        if (sample_valid) begin
            case (state_r)
                BELOW: begin
                    if (v_sample > THRESH) begin
                        spike_s = 1'b1;
                        state_s = ABOVE;
                    end else begin
                        state_s = BELOW;
                    end
                end
                ABOVE: begin
                    if (v9_s < REARM9) begin
                        state_s = BELOW;
                    end else begin
                        state_s = ABOVE;
                    end
                end
                default: begin
                    state_s = BELOW;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // ISI counter and first-spike marker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_cnt_r       <= {ISI_W{1'b0}};
            first_pending_r <= 1'b1;
        end else if (sample_valid) begin
            if (spike_s) begin
                isi_cnt_r       <= {ISI_W{1'b0}};
                first_pending_r <= 1'b0;
            end else begin
                isi_cnt_r       <= isi_inc_s;
            end
        end
    end

    // Registered spike pulse and sticky drop flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            spike_out_r <= spike_s;
            if (spike_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    izh_evt_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (spike_s),
        .push_data (evt_s),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (evt_data)
    );

    assign spike_out = spike_out_r;
    assign overflow  = overflow_r;
    assign evt_valid = !fifo_empty_s;

`ifdef SPIKE_RATE_EN
    logic [15:0] win_cnt_r;
    logic [15:0] acc_r;
    logic [15:0] acc_next_s;
    logic [15:0] rate_count_r;
    logic        rate_valid_r;

    assign acc_next_s = (spike_s && (acc_r != 16'hFFFF)) ? (acc_r + 16'd1) : acc_r;

    // Sample window: publish spike count at the window's last valid sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_r    <= 16'd0;
            acc_r        <= 16'd0;
            rate_count_r <= 16'd0;
            rate_valid_r <= 1'b0;
        end else begin
            rate_valid_r <= 1'b0;
            if (sample_valid) begin
                if (win_cnt_r == (WINDOW - 16'd1)) begin
                    win_cnt_r    <= 16'd0;
                    acc_r        <= 16'd0;
                    rate_count_r <= acc_next_s;
                    rate_valid_r <= 1'b1;
                end else begin
                    win_cnt_r    <= win_cnt_r + 16'd1;
                    acc_r        <= acc_next_s;
                end
            end
        end
    end

    assign rate_count = rate_count_r;
    assign rate_valid = rate_valid_r;
`else
    assign rate_count = 16'd0;
    assign rate_valid = 1'b0;
`endif

endmodule

// File: doc/izh_spike_decoder.md
Name: izh_spike_decoder

Overview:
- Receive end of the neuron's membrane-voltage output stream.
- Consumes the 8-bit signed 2.6-format voltage samples the neuron core emits (upper bits of its 2.16 state).
- Detects spikes using a threshold with hysteresis, measures inter-spike interval (ISI) in valid samples, and flags bursts.
- Queues one event per spike into a small FIFO read through a valid/ready handshake; downstream is a classifier or host readout.

Parameters:
- THRESH, 8'sd16, spike threshold in 2.6 format (0.25); crossing requires sample strictly greater than THRESH.
- HYST, 8'd8, re-arm hysteresis; re-arm when sample < THRESH - HYST.
- ISI_W, 12, ISI counter width; counter saturates at 2^ISI_W-1.
- BURST_ISI, 12'd8, ISI at or below this value marks a burst spike.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two.
- WINDOW, 16'd1024, rate window length in valid samples (used only with SPIKE_RATE_EN).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous, active-low reset
- sample_valid  input  1  v_sample is valid this cycle
- v_sample  input  8  signed 2.6 membrane voltage
- spike_out  output  1  one-cycle pulse per detected spike
- evt_valid  output  1  FIFO non-empty
- evt_ready  input  1  consumer accepts the head entry
- evt_data  output  ISI_W+2  {first, burst, isi}
- overflow  output  1  sticky flag: an event was dropped
- rate_count  output  16  spikes in the last complete window
- rate_valid  output  1  one-cycle pulse when rate_count updates

Behaviour:
- Reset (rst_n=0 at posedge, synchronous, active-low, clock clk):
  - FSM goes to BELOW; isi_cnt=0; first_pending=1.
  - FIFO empties; spike_out, evt_valid, overflow, rate_valid = 0; rate_count = 0.
  - evt_data is 0 while empty.
  - Reset asserted mid-operation discards all queued events and partial counts.
- Samples are processed only on cycles with sample_valid=1. All other state holds otherwise; the FIFO still pops.
- isi_cnt increments by 1 on every valid sample, saturating at 2^ISI_W-1.
- FSM, two states:
  - BELOW: if v_sample > THRESH (signed compare), this is a spike sample. Go to ABOVE.
  - ABOVE: if v_sample < THRESH - HYST, go to BELOW. Evaluate the difference in 9-bit signed so it cannot wrap. No spike is detected while in ABOVE.
- On a spike sample:
  - isi = saturate(isi_cnt + 1); isi_cnt is then cleared to 0.
  - first = first_pending; first_pending is then cleared.
  - burst = !first && (isi <= BURST_ISI).
  - Example: spikes at valid samples n and n+k give isi = k.
- Latency: spike_out is registered and pulses the cycle after the spike sample. The event is visible on evt_valid that same cycle if the FIFO was empty.
- FIFO:
  - Pop occurs when evt_valid && evt_ready.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle (simultaneous push+pop when full is allowed).
  - A push while full with no pop is dropped and sets overflow, which stays high until reset.
  - FIFO order is preserved; evt_data shows the head entry.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
- Arithmetic: all voltage compares are signed. Counters are unsigned and saturating, never wrapping.

Optional Feature:
- Macro: SPIKE_RATE_EN.
- With it defined:
  - A window counter counts valid samples from 0 to WINDOW-1.
  - A spike accumulator counts spikes within the window.
  - On the valid sample ending the window, the registered rate_count takes the accumulator value (including a spike on that same sample) and rate_valid pulses 1 cycle later.
  - The accumulator restarts at 0 (or 1 if the next sample spikes).
- Without it: rate_count is tied to 0, rate_valid is tied to 0, and no window logic is generated. The ports remain present.

Decomposition:
- Package izh_spike_pkg holds:
  - ISI_W default, EVT_W = ISI_W+2.
  - The event typedef {first, burst, isi}.
  - The FSM state enum {BELOW, ABOVE}.
  - The 2.6 format constants: ONE = 8'sd64, and the default threshold and hysteresis.
- One sub-module, izh_evt_fifo: a parameterised synchronous FIFO with push/pop/full/empty. The decoder instantiates it once.

Test Plan:
- Reset, then samples -32, -32, 20, 30, 5, -32 → one spike_out pulse the cycle after sample 20; evt_data = {1, 0, 3}; no spike on 30; re-arm on 5 (< 8).
- Spikes on valid samples 10 and 16 after reset, with sample_valid gapped randomly → second event isi = 6, burst = 1, first = 0. Gaps do not count.
- Spikes 20 samples apart with BURST_ISI = 8 → burst = 0, isi = 20.
- evt_ready held 0, six spikes → first 4 events retained in order; overflow = 1 after the 5th; pop with a simultaneous push at full accepts the new event.
- No spike for 5000 samples, then a spike → isi = 4095 (saturated).
- Assert rst_n = 0 with 3 events queued and FSM in ABOVE → next cycle evt_valid = 0, overflow = 0, FSM BELOW. With SPIKE_RATE_EN and WINDOW = 64, 5 spikes in the window → rate_count = 5 and one rate_valid pulse.
